mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 4, max consecutive data grants while fetch waits (range 1..15).
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 if_req  input  1  fetch read request; held high until if_done.
REQ-005 if_addr  input  32  fetch byte address.
REQ-006 if_done  output  1  one-cycle pulse when the fetch read completes.
REQ-007 if_rdata  output  32  fetch read data; valid with if_done, held otherwise.
REQ-008 dm_req  input  1  data-stage request; held high until dm_done.
REQ-009 dm_we  input  1  1 = store, 0 = load.
REQ-010 dm_addr  input  32  data byte address.
REQ-011 dm_wdata  input  32  store data.
REQ-012 dm_done  output  1  one-cycle pulse when the data access completes (load or store).
REQ-013 dm_rdata  output  32  load data; valid with dm_done on loads, held otherwise.
REQ-014 mem_req  output  1  request to the shared single-port memory.
REQ-015 mem_we  output  1  write enable to memory.
REQ-016 mem_addr  output  32  memory address.
REQ-017 mem_wdata  output  32  memory write data.
REQ-018 mem_ack  input  1  memory completion, one-cycle pulse, arbitrary latency >= 1 cycle after mem_req rises.
REQ-019 mem_rdata  input  32  memory read data, valid with mem_ack.
REQ-020 stall_if  output  1  combinational: if_req & ~if_done, to freeze PC and IF/ID.
REQ-021 stall_mem  output  1  combinational: dm_req & ~dm_done, to freeze the pipeline behind EX/MEM.

Function
REQ-022 FSM states: IDLE, BUSY_IF, BUSY_DM.
- IDLE: if no request, stay.
- IDLE with a request: choose owner; register address, we and wdata; go to BUSY_IF or BUSY_DM.
REQ-023 Arbitration in IDLE:
- dm_req alone -> BUSY_DM; if_req alone -> BUSY_IF.
- Both -> BUSY_DM, except as in REQ-030.
REQ-024 In BUSY_*: mem_req=1; mem_we/mem_addr/mem_wdata driven from the registered fields, stable until mem_ack; the owner's fetch reads always drive mem_we=0.
REQ-025 On mem_ack in BUSY_*: next state IDLE; the owner's done pulses the following cycle; on reads, the owner's rdata register loads mem_rdata.
REQ-026 Minimum transaction: grant cycle, >=1 busy cycle, done cycle; a new grant is possible in the done cycle (FSM already in IDLE).
REQ-027 Requester inputs are ignored while BUSY_*; a req deassert mid-transaction does not abort it.
REQ-028 The requester must drop req in the done cycle. A req still high in the done cycle is treated as a new request.
REQ-029 mem_ack in IDLE is ignored; no done pulse and no state change.

Reset
REQ-030 Starvation guard (only with the macro in REQ-035):
- 4-bit counter increments on each BUSY_DM grant made while if_req=1.
- When counter == STARVE_LIMIT and both request, fetch wins.
- Counter clears on any BUSY_IF grant.
REQ-031 rst sampled high: next edge sets FSM=IDLE, mem_req=0, mem_we=0, if_done=0, dm_done=0, counter=0, registered address/wdata=0, if_rdata=0, dm_rdata=0.
REQ-032 Reset mid-transaction aborts it: no done pulse is issued, and a later mem_ack is ignored per REQ-029.
REQ-033 rst has priority over every other event in the same cycle.

Configuration
REQ-034 No other configuration parameters.
REQ-035 Macro ARB_STARVE_GUARD_EN:
- Defined: REQ-030 active.
- Undefined: pure fixed data priority, the counter is not implemented, and fetch can starve indefinitely.

Verification
REQ-036 Fetch alone: if_req=1, if_addr=0x100, mem_ack 2 cycles after mem_req, mem_rdata=0x00500093 -> mem_addr=0x100, mem_we=0, if_done one pulse, if_rdata=0x00500093, stall_if low after the pulse.
REQ-037 Simultaneous: if_req and dm_req (store, 0x2000, 0xDEADBEEF) in the same IDLE cycle -> store serviced first (mem_we=1, mem_wdata=0xDEADBEEF), then fetch; stall_if stays high throughout the store.
REQ-038 Starvation, macro defined, STARVE_LIMIT=4: dm_req continuous with if_req continuous -> 4 data grants, then a fetch grant, then the pattern repeats. With the macro undefined -> no fetch grant occurs.
REQ-039 Reset mid-op: rst asserted while in BUSY_DM, mem_ack arrives 1 cycle after rst is released -> no dm_done, mem_req=0, FSM stays IDLE.
REQ-040 Back-to-back loads: dm_req held across dm_done for a second load at 0x2004 -> second grant in the done cycle, mem_addr=0x2004, dm_rdata updates only on each dm_done.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between instruction fetch and the data stage.
// Define ARB_STARVE_GUARD_EN to let fetch win after STARVE_LIMIT consecutive data grants.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_done,
  output logic [31:0] dm_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall_if,
  output logic        stall_mem
);
  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_t;
  state_t state_q, state_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
  logic we_q, we_d, if_done_q, if_done_d, dm_done_q, dm_done_d, pick_if;
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("STARVE_LIMIT must be within 1..15");
  end
`ifdef ARB_STARVE_GUARD_EN
  logic [3:0] cnt_q, cnt_d;
  assign pick_if = if_req & (~dm_req | (cnt_q == 4'(STARVE_LIMIT)));
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE && pick_if) cnt_d = 4'd0;
    else if (state_q == IDLE && dm_req && if_req) cnt_d = cnt_q + 4'd1;
  end
  always_ff @(posedge clk) cnt_q <= rst ? 4'd0 : cnt_d;
`else
  assign pick_if = if_req & ~dm_req;
`endif
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    if_done_d  = 1'b0;
    dm_done_d  = 1'b0;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    if (state_q == IDLE) begin
      if (pick_if) begin
        state_d = BUSY_IF;
        addr_d  = if_addr;
        we_d    = 1'b0;
        wdata_d = 32'd0;
      end else if (dm_req) begin
        state_d = BUSY_DM;
        addr_d  = dm_addr;
        we_d    = dm_we;
        wdata_d = dm_wdata;
      end
    end else if (mem_ack) begin
      state_d = IDLE;
      if (state_q == BUSY_IF) begin
        if_done_d  = 1'b1;
        if_rdata_d = mem_rdata;
      end else begin
        dm_done_d  = 1'b1;
        dm_rdata_d = we_q ? dm_rdata_q : mem_rdata;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= 32'd0;
      we_q       <= 1'b0;
      wdata_q    <= 32'd0;
      if_done_q  <= 1'b0;
      dm_done_q  <= 1'b0;
      if_rdata_q <= 32'd0;
      dm_rdata_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      if_done_q  <= if_done_d;
      dm_done_q  <= dm_done_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end
  assign mem_req   = state_q != IDLE;
  assign mem_we    = we_q & mem_req;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_done   = if_done_q;
  assign dm_done   = dm_done_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign stall_if  = if_req & ~if_done_q;
  assign stall_mem = dm_req & ~dm_done_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a variable-latency memory model.
module tb_mem_arbiter;
`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif
  logic clk, rst, if_req, if_done, dm_req, dm_we, dm_done, mem_req, mem_we, mem_ack, stall_if, stall_mem;
  logic [31:0] if_addr, if_rdata, dm_addr, dm_wdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
  typedef struct {logic [31:0] addr; logic we; logic [31:0] wdata;} grant_t;
  typedef struct {logic is_if; logic [31:0] rdata; logic chk_rd;} done_t;
  grant_t gq[$];
  done_t dq[$];
  grant_t ge;
  done_t de;
  int n_chk = 0, n_pass = 0, lat = 1;
  logic auto_ack = 1'b1, prev_req = 1'b0, i_dn, d_dn;
  logic [31:0] exp_if = 32'd0, exp_dm = 32'd0, cur_addr = 32'd0;

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_done(dm_done),
    .dm_rdata(dm_rdata), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_mem(stall_mem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rd(input logic [31:0] a);
    return a == 32'h100 ? 32'h0050_0093 : a ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
  endtask

  task automatic push_g(input logic [31:0] a, input logic we, input logic [31:0] wd);
    gq.push_back('{addr: a, we: we, wdata: wd});
  endtask

  task automatic push_d(input logic is_if, input logic [31:0] r, input logic c);
    dq.push_back('{is_if: is_if, rdata: r, chk_rd: c});
  endtask

  task automatic wait_dn(output logic i, output logic d, input logic stall_chk);
    i = 1'b0;
    d = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (stall_chk) chk("stall_if_hi", stall_if, 1);
      if (if_done | dm_done) begin
        i = if_done;
        d = dm_done;
        break;
      end
    end
    chk("done_seen", i | d, 1);
  endtask

  // memory model: ack lat+1 cycles after mem_req rises
  initial begin
    int wc = 0;
    mem_ack = 1'b0;
    mem_rdata = 32'd0;
    forever begin
      @(negedge clk);
      if (auto_ack) begin
        mem_ack = 1'b0;
        if (mem_req === 1'b1 && !rst) begin
          if (wc == lat) begin
            mem_ack = 1'b1;
            mem_rdata = rd(mem_addr);
            wc = 0;
          end else wc++;
        end else wc = 0;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (mem_req && !prev_req) begin
        if (gq.size() == 0) chk("grant_unexp", gq.size(), 1);
        else begin
          ge = gq.pop_front();
          chk("g_addr", mem_addr, ge.addr);
          chk("g_we", mem_we, ge.we);
          if (ge.we) chk("g_wdata", mem_wdata, ge.wdata);
          cur_addr = mem_addr;
        end
      end else if (mem_req) chk("addr_stable", mem_addr, cur_addr);
      if (if_done | dm_done) begin
        if (dq.size() == 0) chk("done_unexp", dq.size(), 1);
        else begin
          de = dq.pop_front();
          chk("done_owner", if_done, de.is_if);
          chk("done_single", if_done & dm_done, 0);
          if (de.chk_rd && de.is_if) exp_if = de.rdata;
          if (de.chk_rd && !de.is_if) exp_dm = de.rdata;
        end
      end
      chk("if_rdata", if_rdata, exp_if);
      chk("dm_rdata", dm_rdata, exp_dm);
    end
    prev_req = mem_req;
  end

  initial begin
    rst = 1'b1;
    if_req = 1'b0; if_addr = 32'd0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = 32'd0; dm_wdata = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_if_done", if_done, 0);
    chk("rst_dm_done", dm_done, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_dm_rdata", dm_rdata, 0);
    rst = 1'b0;
    // fetch alone
    push_g(32'h100, 1'b0, 32'd0);
    push_d(1'b1, 32'h0050_0093, 1'b1);
    if_addr = 32'h100;
    if_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t1_stall_busy", stall_if, 1);
    wait_dn(i_dn, d_dn, 1'b0);
    chk("t1_if_done", i_dn, 1);
    chk("t1_if_rdata", if_rdata, 32'h0050_0093);
    if_req = 1'b0;
    @(negedge clk);
    chk("t1_stall_after", stall_if, 0);
    chk("t1_pulse_one", if_done, 0);
    // simultaneous store and fetch: store first
    push_g(32'h2000, 1'b1, 32'hDEAD_BEEF);
    push_d(1'b0, 32'd0, 1'b0);
    push_g(32'h104, 1'b0, 32'd0);
    push_d(1'b1, rd(32'h104), 1'b1);
    dm_we = 1'b1; dm_addr = 32'h2000; dm_wdata = 32'hDEAD_BEEF; dm_req = 1'b1;
    if_addr = 32'h104; if_req = 1'b1;
    wait_dn(i_dn, d_dn, 1'b1);
    chk("t2_store_first", d_dn, 1);
    dm_req = 1'b0; dm_we = 1'b0;
    wait_dn(i_dn, d_dn, 1'b0);
    chk("t2_fetch_second", i_dn, 1);
    if_req = 1'b0;
    @(negedge clk);
    // back-to-back loads, second granted in the done cycle
    push_g(32'h2000, 1'b0, 32'd0);
    push_d(1'b0, rd(32'h2000), 1'b1);
    push_g(32'h2004, 1'b0, 32'd0);
    push_d(1'b0, rd(32'h2004), 1'b1);
    dm_addr = 32'h2000; dm_req = 1'b1;
    wait_dn(i_dn, d_dn, 1'b0);
    chk("t3_first", d_dn, 1);
    dm_addr = 32'h2004;
    @(negedge clk);
    chk("t3_regrant", mem_req, 1);
    wait_dn(i_dn, d_dn, 1'b0);
    chk("t3_second", d_dn, 1);
    dm_req = 1'b0;
    @(negedge clk);
    // both requesting continuously
    for (int k = 0; k < 10; k++) begin
      logic f;
      f = GUARD && (k % 5 == 4);
      push_g(f ? 32'h100 : 32'h2000, 1'b0, 32'd0);
      push_d(f, rd(f ? 32'h100 : 32'h2000), 1'b1);
    end
    dm_addr = 32'h2000; if_addr = 32'h100; dm_req = 1'b1; if_req = 1'b1;
    for (int k = 0; k < 10; k++) wait_dn(i_dn, d_dn, 1'b0);
    dm_req = 1'b0; if_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("t4_idle", mem_req, 0);
    // reset while busy, late ack in idle ignored
    auto_ack = 1'b0;
    push_g(32'h3000, 1'b0, 32'd0);
    dm_addr = 32'h3000; dm_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t5_busy", mem_req, 1);
    rst = 1'b1; dm_req = 1'b0; exp_if = 32'd0; exp_dm = 32'd0;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_rst_req", mem_req, 0);
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    mem_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("t5_no_req", mem_req, 0);
      chk("t5_no_done", dm_done, 0);
      @(negedge clk);
    end
    chk("gq_empty", gq.size(), 0);
    chk("dq_empty", dq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
